// File: rtl/auth_sequencer_if.sv
// Signal bundle between the authentication sequencer and its environment
// (button shapers, ID ROM, password manager).
interface auth_sequencer_if #(
  parameter int ADDR_W = 3
);
  logic              id_start;
  logic [15:0]       entered_id;
  logic [ADDR_W-1:0] rom_addr;
  logic [15:0]       rom_data;
  logic              pwd_check_req;
  logic              pwd_check_ack;
  logic              pwd_match;
  logic [ADDR_W-1:0] user_idx;
  logic              id_found;
  logic              access_granted;
  logic              locked;
  logic              busy;
  logic [1:0]        fail_count;

  modport master (
    input  id_start, entered_id, rom_data, pwd_check_ack, pwd_match,
    output rom_addr, pwd_check_req, user_idx, id_found, access_granted,
           locked, busy, fail_count
  );

  modport slave (
    output id_start, entered_id, rom_data, pwd_check_ack, pwd_match,
    input  rom_addr, pwd_check_req, user_idx, id_found, access_granted,
           locked, busy, fail_count
  );
endinterface

// File: rtl/auth_sequencer.sv
// Runs one authentication attempt: pipelined ID ROM scan, password check handshake,
// consecutive-failure counting and timed grant/lockout windows.
module auth_sequencer #(
  parameter int NUM_USERS    = 8,
  parameter int ADDR_W       = 3,
  parameter int MAX_FAILS    = 3,
  parameter int LOCK_CYCLES  = 50000,
  parameter int GRANT_CYCLES = 1000,
  parameter int PWD_TIMEOUT  = 255
) (
  input logic             clk,
  input logic             rst,
  auth_sequencer_if.master bus
);

  localparam int TMAX_A  = (LOCK_CYCLES > GRANT_CYCLES) ? LOCK_CYCLES : GRANT_CYCLES;
  localparam int TMAX    = (TMAX_A > PWD_TIMEOUT) ? TMAX_A : PWD_TIMEOUT;
  localparam int TIMER_W = $clog2(TMAX + 1);
  localparam int CNT_W   = $clog2(NUM_USERS + 1);

  localparam logic [CNT_W-1:0]   LAST_CMP   = CNT_W'(NUM_USERS);
  localparam logic [ADDR_W-1:0]  LAST_ADDR  = ADDR_W'(NUM_USERS - 1);
  localparam logic [TIMER_W-1:0] PWD_LAST   = TIMER_W'(PWD_TIMEOUT - 1);
  localparam logic [TIMER_W-1:0] GRANT_LAST = TIMER_W'(GRANT_CYCLES - 1);
  localparam logic [TIMER_W-1:0] LOCK_LAST  = TIMER_W'(LOCK_CYCLES - 1);
  localparam logic [1:0]         MAX_FC     = 2'(MAX_FAILS);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_SCAN     = 3'd1,
    S_WAIT_PWD = 3'd2,
    S_GRANT    = 3'd3,
    S_LOCKOUT  = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [ADDR_W-1:0]  rom_addr_q, rom_addr_d;
  logic [ADDR_W-1:0]  user_idx_q, user_idx_d;
  logic               req_q, req_d;
  logic               id_found_q, id_found_d;
  logic               granted_q, granted_d;
  logic               locked_q, locked_d;
  logic               busy_q, busy_d;
  logic [1:0]         fail_count_q, fail_count_d;
  logic               fail_s;
  logic               lock_next_s;
  logic [1:0]         fail_inc_s;

  // Next-state and next-output computation for the whole sequencer.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    timer_d      = timer_q;
    rom_addr_d   = rom_addr_q;
    user_idx_d   = user_idx_q;
    req_d        = req_q;
    id_found_d   = id_found_q;
    granted_d    = granted_q;
    locked_d     = locked_q;
    busy_d       = busy_q;
    fail_count_d = fail_count_q;
    fail_s       = 1'b0;
    fail_inc_s   = (fail_count_q == MAX_FC) ? MAX_FC : fail_count_q + 2'd1;
    lock_next_s  = (fail_inc_s == MAX_FC);

    case (state_q)
      S_IDLE: begin
        if (bus.id_start) begin
          state_d    = S_SCAN;
          cnt_d      = '0;
          rom_addr_d = '0;
          busy_d     = 1'b1;
        end else begin
          busy_d = 1'b0;
        end
      end
      // cnt_q is the address presented; rom_data belongs to address cnt_q-1.
      S_SCAN: begin
        if ((cnt_q != '0) && (bus.rom_data == bus.entered_id)) begin
          state_d    = S_WAIT_PWD;
          user_idx_d = ADDR_W'(cnt_q - CNT_W'(1));
          id_found_d = 1'b1;
          req_d      = 1'b1;
          timer_d    = '0;
          rom_addr_d = '0;
        end else if (cnt_q == LAST_CMP) begin
          fail_s     = 1'b1;
          rom_addr_d = '0;
        end else begin
          cnt_d      = cnt_q + CNT_W'(1);
          rom_addr_d = (rom_addr_q == LAST_ADDR) ? LAST_ADDR : rom_addr_q + ADDR_W'(1);
        end
      end
      S_WAIT_PWD: begin
        if (bus.pwd_check_ack) begin
          req_d = 1'b0;
          if (bus.pwd_match) begin
            state_d      = S_GRANT;
            granted_d    = 1'b1;
            fail_count_d = 2'd0;
            timer_d      = '0;
          end else begin
            fail_s = 1'b1;
          end
        end else if (timer_q == PWD_LAST) begin
          req_d  = 1'b0;
          fail_s = 1'b1;
        end else begin
          timer_d = timer_q + TIMER_W'(1);
        end
      end
      S_GRANT: begin
        if (timer_q == GRANT_LAST) begin
          state_d    = S_IDLE;
          granted_d  = 1'b0;
          busy_d     = 1'b0;
          id_found_d = 1'b0;
        end else begin
          timer_d = timer_q + TIMER_W'(1);
        end
      end
      S_LOCKOUT: begin
        if (timer_q == LOCK_LAST) begin
          state_d      = S_IDLE;
          locked_d     = 1'b0;
          busy_d       = 1'b0;
          id_found_d   = 1'b0;
          fail_count_d = 2'd0;
        end else begin
          timer_d = timer_q + TIMER_W'(1);
        end
      end
      default: begin
        state_d    = S_IDLE;
        req_d      = 1'b0;
        granted_d  = 1'b0;
        locked_d   = 1'b0;
        busy_d     = 1'b0;
        id_found_d = 1'b0;
      end
    endcase

    // A failed attempt either returns to IDLE or, on reaching the limit, locks out.
    fail_count_d = fail_s ? fail_inc_s : fail_count_d;
    timer_d      = fail_s ? '0 : timer_d;
    state_d      = fail_s ? (lock_next_s ? S_LOCKOUT : S_IDLE) : state_d;
    locked_d     = fail_s ? lock_next_s : locked_d;
    busy_d       = fail_s ? lock_next_s : busy_d;
    id_found_d   = fail_s ? (id_found_d & lock_next_s) : id_found_d;
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      timer_q      <= '0;
      rom_addr_q   <= '0;
      user_idx_q   <= '0;
      req_q        <= 1'b0;
      id_found_q   <= 1'b0;
      granted_q    <= 1'b0;
      locked_q     <= 1'b0;
      busy_q       <= 1'b0;
      fail_count_q <= 2'd0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      timer_q      <= timer_d;
      rom_addr_q   <= rom_addr_d;
      user_idx_q   <= user_idx_d;
      req_q        <= req_d;
      id_found_q   <= id_found_d;
      granted_q    <= granted_d;
      locked_q     <= locked_d;
      busy_q       <= busy_d;
      fail_count_q <= fail_count_d;
    end
  end

  assign bus.rom_addr       = rom_addr_q;
  assign bus.user_idx       = user_idx_q;
  assign bus.pwd_check_req  = req_q;
  assign bus.id_found       = id_found_q;
  assign bus.access_granted = granted_q;
  assign bus.locked         = locked_q;
  assign bus.busy           = busy_q;
  assign bus.fail_count     = fail_count_q;

endmodule
